// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_pkg                                                    |
// | Description : Shared types for the sequential ALU: opcode encoding,      |
// |               NZCV flag record, control-state encoding and the bit       |
// |               positions of each flag on the packed flags output.         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package alu_pkg;

   typedef enum logic [2:0] {
      OP_AND = 3'b000,
      OP_ORR = 3'b001,
      OP_ADD = 3'b010,
      OP_SUB = 3'b011,
      OP_EOR = 3'b100,
      OP_ADC = 3'b101,
      OP_SBC = 3'b110,
      OP_MUL = 3'b111
   } op_e;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      HOLD = 2'd2
   } state_e;

   // Bit positions of each flag on the 4-bit {N,Z,C,V} output.
   localparam int unsigned c_FLAG_N = 3;
   localparam int unsigned c_FLAG_Z = 2;
   localparam int unsigned c_FLAG_C = 1;
   localparam int unsigned c_FLAG_V = 0;

endpackage
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_mul_iter                                               |
// | Description : Iterative shift-add multiplier returning the low WIDTH     |
// |               bits of a_i * b_i. One partial product per cycle, WIDTH    |
// |               cycles after start_i. done_o is asserted during the last   |
// |               step and product_o already includes that final step.       |
// | Revision    : 1.0  initial release                                       |
// | Ports       : clk       rising-edge clock                                |
// |               reset     synchronous active-high reset                    |
// |               start_i   load operands and begin (ignored unless idle     |
// |                         from the parent's point of view)                 |
// |               a_i, b_i  operands, sampled on start_i                     |
// |               done_o    final step in progress this cycle                |
// |               product_o low WIDTH bits of the product while done_o       |
// +--------------------------------------------------------------------------+
module alu_mul_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] product_o
);

   localparam int            c_CW   = $clog2(WIDTH);
   localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);
   localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

   logic             busy_q, busy_d;
   logic [c_CW-1:0]  cnt_q,  cnt_d;
   logic [WIDTH-1:0] a_q,    a_d;
   logic [WIDTH-1:0] b_q,    b_d;
   logic [WIDTH-1:0] acc_q,  acc_d;
   logic [WIDTH-1:0] w_addend;
   logic [WIDTH-1:0] w_acc_next;

   // Multiplicand shifts left while the multiplier shifts right, so bit 0 of
   // b_q always selects whether the current shifted multiplicand is added.
   assign w_addend   = b_q[0] ? a_q : '0;
   assign w_acc_next = acc_q + w_addend;

   assign done_o    = busy_q && (cnt_q == c_LAST);
   assign product_o = w_acc_next;

   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      a_d    = a_q;
      b_d    = b_q;
      acc_d  = acc_q;
      if (start_i) begin
         busy_d = 1'b1;
         cnt_d  = '0;
         a_d    = a_i;
         b_d    = b_i;
         acc_d  = '0;
      end else if (busy_q) begin
         acc_d = w_acc_next;
         a_d   = a_q << 1;
         b_d   = b_q >> 1;
         if (cnt_q == c_LAST) begin
            busy_d = 1'b0;
            cnt_d  = '0;
         end else begin
            cnt_d = cnt_q + c_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         acc_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         a_q    <= a_d;
         b_q    <= b_d;
         acc_q  <= acc_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_seq                                                    |
// | Description : Handshaked execute-stage ALU with registered result and a  |
// |               persistent NZCV flag register. Carry follows the ARM       |
// |               convention (C = NOT borrow on subtract), V is signed       |
// |               overflow. Non-MUL ops complete one cycle after accept;     |
// |               MUL (when ALU_MUL_EN is defined) iterates for WIDTH cycles.|
// |               Without ALU_MUL_EN, opcode 111 completes in one cycle with |
// |               result 0, flags untouched and out_err set.                 |
// |               WIDTH must be at least 4.                                  |
// | Revision    : 1.0  initial release                                       |
// | Ports       : clk        rising-edge clock                               |
// |               reset      synchronous active-high reset                   |
// |               in_valid / in_ready    operation handshake                 |
// |               op, set_flags, src_a, src_b  operation request             |
// |               out_valid / out_ready  result handshake                    |
// |               result, flags {N,Z,C,V}, out_err  completed operation      |
// | Config      : ALU_MUL_EN  enables the iterative multiplier               |
// +--------------------------------------------------------------------------+
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic             set_flags,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic             out_err
);

   state_e           state_q,  state_d;
   logic [WIDTH-1:0] result_q, result_d;
   flags_t           flags_q,  flags_d;
   logic             err_q,    err_d;

   op_e              w_op;
   logic             w_accept;
   logic [WIDTH-1:0] w_b_eff;
   logic             w_cin;
   logic             w_arith;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_alu_res;
   flags_t           w_alu_flags;

   assign w_op     = op_e'(op);
   assign in_ready = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
   assign w_accept = in_valid && in_ready;

   // ---------------------------------------------------------------------
   // Datapath. Subtraction is A + ~B + cin so one WIDTH+1 adder serves all
   // arithmetic ops and its top bit is directly the ARM carry.
   // ---------------------------------------------------------------------
   always_comb begin
      w_b_eff = src_b;
      w_cin   = 1'b0;
      w_arith = 1'b0;
      case (w_op)
         OP_ADD: begin
            w_arith = 1'b1;
         end
         OP_ADC: begin
            w_arith = 1'b1;
            w_cin   = flags_q.c;
         end
         OP_SUB: begin
            w_arith = 1'b1;
            w_b_eff = ~src_b;
            w_cin   = 1'b1;
         end
         OP_SBC: begin
            w_arith = 1'b1;
            w_b_eff = ~src_b;
            w_cin   = flags_q.c;
         end
         default: begin
         end
      endcase
   end

   assign w_sum = {1'b0, src_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin};

   always_comb begin
      w_alu_res = '0;
      case (w_op)
         OP_AND:  w_alu_res = src_a & src_b;
         OP_ORR:  w_alu_res = src_a | src_b;
         OP_EOR:  w_alu_res = src_a ^ src_b;
         OP_ADD,
         OP_ADC,
         OP_SUB,
         OP_SBC:  w_alu_res = w_sum[WIDTH-1:0];
         default: w_alu_res = '0;
      endcase
   end

   // Logic ops keep C and V; arithmetic ops overwrite them.
   always_comb begin
      w_alu_flags   = flags_q;
      w_alu_flags.n = w_alu_res[WIDTH-1];
      w_alu_flags.z = (w_alu_res == '0);
      if (w_arith) begin
         w_alu_flags.c = w_sum[WIDTH];
         w_alu_flags.v = (src_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                         (w_sum[WIDTH-1] != src_a[WIDTH-1]);
      end
   end

`ifdef ALU_MUL_EN
   // ---------------------------------------------------------------------
   // Multiplier. set_flags must be remembered across the BUSY period.
   // ---------------------------------------------------------------------
   logic             setf_q, setf_d;
   logic             w_mul_start;
   logic             w_mul_done;
   logic [WIDTH-1:0] w_mul_product;

   alu_mul_iter #(
      .WIDTH     (WIDTH)
   ) u_mul (
      .clk       (clk),
      .reset     (reset),
      .start_i   (w_mul_start),
      .a_i       (src_a),
      .b_i       (src_b),
      .done_o    (w_mul_done),
      .product_o (w_mul_product)
   );
`endif

   // ---------------------------------------------------------------------
   // Control: next state and register updates. An accept overrides the
   // HOLD->IDLE return so a new op can enter in the same cycle the previous
   // result is consumed.
   // ---------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      flags_d  = flags_q;
      err_d    = err_q;
`ifdef ALU_MUL_EN
      setf_d      = setf_q;
      w_mul_start = 1'b0;
`endif
      case (state_q)
         IDLE: begin
         end
         BUSY: begin
`ifdef ALU_MUL_EN
            if (w_mul_done) begin
               state_d  = HOLD;
               result_d = w_mul_product;
               err_d    = 1'b0;
               if (setf_q) begin
                  flags_d.n = w_mul_product[WIDTH-1];
                  flags_d.z = (w_mul_product == '0);
               end
            end
`else
            state_d = IDLE;
`endif
         end
         HOLD: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (w_accept) begin
         if (w_op == OP_MUL) begin
`ifdef ALU_MUL_EN
            state_d     = BUSY;
            setf_d      = set_flags;
            w_mul_start = 1'b1;
`else
            state_d  = HOLD;
            result_d = '0;
            err_d    = 1'b1;
`endif
         end else begin
            state_d  = HOLD;
            result_d = w_alu_res;
            err_d    = 1'b0;
            if (set_flags) begin
               flags_d = w_alu_flags;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         result_q <= '0;
         flags_q  <= '0;
         err_q    <= 1'b0;
`ifdef ALU_MUL_EN
         setf_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         flags_q  <= flags_d;
         err_q    <= err_d;
`ifdef ALU_MUL_EN
         setf_q   <= setf_d;
`endif
      end
   end

   assign out_valid        = (state_q == HOLD);
   assign result           = result_q;
   assign out_err          = err_q;
   assign flags[c_FLAG_N]  = flags_q.n;
   assign flags[c_FLAG_Z]  = flags_q.z;
   assign flags[c_FLAG_C]  = flags_q.c;
   assign flags[c_FLAG_V]  = flags_q.v;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_alu_seq                                                 |
// | Description : Scoreboard bench for alu_seq (WIDTH = 32). Directed        |
// |               operations push hand-computed results into a queue; a      |
// |               monitor pops and compares on every output transfer.        |
// |               Expected MUL behaviour follows ALU_MUL_EN.                 |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_alu_seq;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [2:0]   op;
   logic         set_flags;
   logic [W-1:0] src_a;
   logic [W-1:0] src_b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic [3:0]   flags;
   logic         out_err;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .set_flags (set_flags),
      .src_a     (src_a),
      .src_b     (src_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags),
      .out_err   (out_err)
   );

   localparam logic [2:0] AND_ = 3'b000, ORR_ = 3'b001, ADD_ = 3'b010, SUB_ = 3'b011;
   localparam logic [2:0] EOR_ = 3'b100, ADC_ = 3'b101, SBC_ = 3'b110, MUL_ = 3'b111;

   typedef struct {
      logic [W-1:0] res;
      logic [3:0]   fl;
      logic         err;
      int           gap;
      string        name;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   int   last_pop = -1000;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input bit ok, input string name, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic chk_eq(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      chk(act === exp, name, act, exp);
   endtask

   // Monitor: every transfer on the output side must match the queue head.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            chk(1'b0, "unexpected_output", result, '0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk_eq({e.name, ".result"}, result, e.res);
            chk_eq({e.name, ".flags"}, {28'd0, flags}, {28'd0, e.fl});
            chk_eq({e.name, ".err"}, {31'd0, out_err}, {31'd0, e.err});
            if (e.gap > 0) chk_eq({e.name, ".gap"}, cyc - last_pop, e.gap);
            last_pop = cyc;
         end
      end
   end

   // Present one op, wait (bounded) until accepted, then drop in_valid.
   task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sf, input bit push, input logic [W-1:0] er,
                        input logic [3:0] ef, input logic ee, input int gap,
                        input string nm, output bit first_ready);
      exp_t e;
      int   n;
      op = o; src_a = a; src_b = b; set_flags = sf; in_valid = 1'b1;
      if (push) begin
         e.res = er; e.fl = ef; e.err = ee; e.gap = gap; e.name = nm;
         sb_q.push_back(e);
      end
      n = 0;
      @(negedge clk);
      first_ready = in_ready;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk(1'b0, {nm, ".accept_timeout"}, {31'd0, in_ready}, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic go(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] er, input logic [3:0] ef, input logic ee,
                     input int gap, input string nm);
      bit fr;
      issue(o, a, b, 1'b1, 1'b1, er, ef, ee, gap, nm, fr);
   endtask

   // Count negedges from the acceptance edge until out_valid (1 = next cycle).
   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 200);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bit fr;
      bit saw;

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0;
      src_a = '0; src_b = '0; set_flags = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk_eq("rst.out_valid", {31'd0, out_valid}, 0);
      chk_eq("rst.in_ready",  {31'd0, in_ready}, 1);
      chk_eq("rst.flags",     {28'd0, flags}, 0);
      chk_eq("rst.result",    result, 0);
      chk_eq("rst.out_err",   {31'd0, out_err}, 0);
      @(posedge clk);
      #1;

      // Arithmetic and flag rules
      go(SUB_, 32'd5, 32'd3, 32'd2, 4'b0010, 1'b0, 0, "sub_5_3");
      go(SUB_, 32'd3, 32'd5, 32'hFFFF_FFFE, 4'b1000, 1'b0, 0, "sub_3_5");
      go(ADD_, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b1001, 1'b0, 0, "add_ovf");
      go(ADD_, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b0110, 1'b0, 0, "add_carry");
      go(ADC_, 32'd0, 32'd0, 32'd1, 4'b0000, 1'b0, 1, "adc_b2b");
      go(SUB_, 32'd5, 32'd3, 32'd2, 4'b0010, 1'b0, 0, "sub_setc");
      go(ORR_, 32'd0, 32'd0, 32'd0, 4'b0110, 1'b0, 0, "orr_zero");
      go(EOR_, 32'h1234_5678, 32'hFFFF_FFFF, 32'hEDCB_A987, 4'b1010, 1'b0, 0, "eor");
      go(AND_, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b1010, 1'b0, 0, "and");
      go(SBC_, 32'd10, 32'd3, 32'd7, 4'b0010, 1'b0, 0, "sbc_c1");
      go(ADD_, 32'd1, 32'd1, 32'd2, 4'b0000, 1'b0, 0, "add_clrc");
      go(SBC_, 32'd10, 32'd3, 32'd6, 4'b0010, 1'b0, 0, "sbc_c0");
      issue(ADD_, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 32'd0, 4'b0010, 1'b0, 0, "add_nosf", fr);
      go(ADC_, 32'd0, 32'd0, 32'd1, 4'b0000, 1'b0, 0, "adc_c1");
      wait_valid(n);
      chk_eq("lat_nonmul", n, 1);
      @(posedge clk);
      #1;

      // Multiply (C and V held from the preceding SUB)
      go(SUB_, 32'd5, 32'd3, 32'd2, 4'b0010, 1'b0, 0, "sub_pre_mul");
`ifdef ALU_MUL_EN
      go(MUL_, 32'd7, 32'd6, 32'd42, 4'b0010, 1'b0, 0, "mul_7_6");
      wait_valid(n);
      chk_eq("lat_mul", n, 33);
      @(posedge clk);
      #1;
      go(MUL_, 32'h0001_0000, 32'h0001_0000, 32'd0, 4'b0110, 1'b0, 0, "mul_zero");
`else
      go(MUL_, 32'd7, 32'd6, 32'd0, 4'b0010, 1'b1, 0, "mul_7_6");
      wait_valid(n);
      chk_eq("lat_mul", n, 1);
      @(posedge clk);
      #1;
      go(MUL_, 32'h0001_0000, 32'h0001_0000, 32'd0, 4'b0010, 1'b1, 0, "mul_zero");
`endif
      wait_valid(n);
      @(posedge clk);
      #1;

      // Backpressure: result held while out_ready is low
      out_ready = 1'b0;
      go(ADD_, 32'd2, 32'd3, 32'd5, 4'b0000, 1'b0, 0, "add_bp");
      wait_valid(n);
      for (int i = 0; i < 5; i++) begin
         chk(out_valid === 1'b1 && in_ready === 1'b0 && result === 32'd5 && flags === 4'b0000,
             "hold_stable", result, 32'd5);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      issue(ORR_, 32'h0000_00A0, 32'h0000_000B, 1'b1, 1'b1, 32'h0000_00AB, 4'b0000, 1'b0,
            1, "orr_after_bp", fr);
      chk_eq("bp_same_cycle_accept", {31'd0, fr}, 1);
      wait_valid(n);
      @(posedge clk);
      #1;

      // Reset in the middle of an operation
      go(SUB_, 32'd3, 32'd5, 32'hFFFF_FFFE, 4'b1000, 1'b0, 0, "sub_pre_rst");
      wait_valid(n);
      @(posedge clk);
      #1;
`ifdef ALU_MUL_EN
      issue(MUL_, 32'd7, 32'd6, 1'b1, 1'b0, '0, '0, 1'b0, 0, "mul_abandon", fr);
      repeat (10) @(posedge clk);
`else
      out_ready = 1'b0;
      issue(ADD_, 32'd1, 32'd2, 1'b1, 1'b0, '0, '0, 1'b0, 0, "add_abandon", fr);
      repeat (3) @(posedge clk);
`endif
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk_eq("rst2.out_valid", {31'd0, out_valid}, 0);
      chk_eq("rst2.flags",     {28'd0, flags}, 0);
      chk_eq("rst2.in_ready",  {31'd0, in_ready}, 1);
      chk_eq("rst2.result",    result, 0);
      saw = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) saw = 1'b1;
         @(negedge clk);
      end
      chk_eq("no_stale_output", {31'd0, saw}, 0);
      @(posedge clk);
      #1;
      go(ADD_, 32'd1, 32'd2, 32'd3, 4'b0000, 1'b0, 0, "add_post_rst");

      n = 0;
      while (sb_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk_eq("scoreboard_drained", sb_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the CPU's combinational ALU. It registers its result and a persistent NZCV flag register, and computes overflow and carry to ARM rules (signed V, carry = NOT borrow on subtract). It adds EOR, ADC and SBC, plus an optional iterative multiplier. It sits in the execute stage between operand fetch and writeback and issues one operation at a time under valid/ready flow control.

## Interface
- WIDTH, 32: operand and result width; must be at least 4.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and opcode valid.
- in_ready  out  1  block can accept an operation.
- op  in  3  opcode (see Operation).
- set_flags  in  1  update NZCV when this operation completes.
- src_a  in  WIDTH  operand A.
- src_b  in  WIDTH  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- flags  out  4  registered {N,Z,C,V}.
- out_err  out  1  the completed operation was unsupported.

## Operation
- Opcodes:
  - 000 AND
  - 001 ORR
  - 010 ADD
  - 011 SUB (A−B)
  - 100 EOR
  - 101 ADC (A+B+C)
  - 110 SBC (A−B−!C)
  - 111 MUL (low WIDTH bits of A×B)
- Arithmetic is done at WIDTH+1 bits.
  - ADD/ADC: C = bit WIDTH of the sum.
  - SUB/SBC: computed as A + ~B + cin, with cin = 1 for SUB and cin = C for SBC. C = bit WIDTH of that sum, so C = 1 means no borrow.
  - V = (A[msb] == B'[msb]) && (R[msb] != A[msb]), where B' is the actually-added operand.
- Flag updates:
  - Logic ops and MUL update N and Z only; C and V are held.
  - All arithmetic ops update N, Z, C and V.
  - N = result MSB; Z = (result == 0).
  - Flags change only when set_flags was 1 at acceptance.
- ADC/SBC read the C flag as registered at the acceptance edge.
- State machine:
  - IDLE: in_ready = 1. On accept, a non-MUL op goes to HOLD; MUL goes to BUSY.
  - BUSY: WIDTH-step shift-add multiply with a count register from 0 to WIDTH−1, and in_ready = 0. When the count reaches WIDTH−1, go to HOLD.
  - HOLD: out_valid = 1. result, flags and out_err are stable until out_ready.
    - On out_ready with in_valid also high, accept the next op in the same cycle: go to HOLD or BUSY.
    - On out_ready with in_valid low, go to IDLE.
- in_ready = (state == IDLE) || (state == HOLD && out_ready).
- flags and result registers are written on entry to HOLD, so a back-to-back ADC sees the previous op's carry.
- Reset values: state = IDLE, out_valid = 0, result = 0, flags = 4'b0000, out_err = 0, multiplier count = 0. in_ready = 1 from the first cycle after reset.
- Reset during BUSY or HOLD abandons the operation and produces no output.
- Opcode decode is exhaustive; no X propagation.

## Timing
- Non-MUL op: accepted at edge T; out_valid is high after edge T+1's preceding edge, i.e. in the cycle following acceptance (latency 1).
- MUL: accepted at T; out_valid is high WIDTH+1 cycles after acceptance (WIDTH cycles in BUSY).
- Throughput: one non-MUL op per cycle when out_ready is held high.
- out_ready is ignored while out_valid = 0.

## Configuration
- ALU_MUL_EN defined: MUL is implemented as above.
- ALU_MUL_EN undefined:
  - Opcode 111 goes directly to HOLD with latency 1.
  - result = 0, flags unchanged, out_err = 1.
  - No multiplier logic is synthesised.
- out_err is 0 for every other opcode in both builds.

## Structure
- alu_pkg holds:
  - the op_e opcode enum (3-bit);
  - the flags_t packed struct {n, z, c, v};
  - the state_e enum {IDLE, BUSY, HOLD};
  - localparams for the flag bit indices.
- Sub-module alu_mul_iter holds the shift-add multiplier: start/done, WIDTH-parameterised, and instantiated only under ALU_MUL_EN.

## Test plan
All cases use WIDTH = 32 and set_flags = 1 unless stated.
- SUB 5−3 → result 2, NZCV = 0010; SUB 3−5 → result 0xFFFFFFFE, NZCV = 1000.
- ADD 0x7FFFFFFF+1 → result 0x80000000, NZCV = 1001.
- ADD 0xFFFFFFFF+1 → result 0, NZCV = 0110. Then a back-to-back ADC 0+0 → result 1, NZCV = 0000, with a 1-cycle gap between results.
- MUL 7×6 (ALU_MUL_EN defined) → result 42, out_valid 33 cycles after accept, C and V held from the prior op. With the macro undefined → result 0, out_err = 1 after 1 cycle.
- Backpressure: hold out_ready low for 5 cycles in HOLD → result/flags stable and in_ready = 0. Then assert out_ready with in_valid high → new op accepted in the same cycle.
- Assert reset during BUSY (MUL at step 10) → the next cycle shows out_valid = 0, flags = 0000, in_ready = 1, and no stale result ever appears.
